// File: rtl/seq_div16x8.sv
// seq_div16x8: sequential restoring divider, DW-bit dividend by VW-bit divisor.
// Produces one quotient bit per clock. Start is a level-sampled request taken
// only in IDLE. A zero divisor completes immediately with an all-ones quotient
// and the low dividend bits as remainder, and flags dz.
module seq_div16x8 #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          dz
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_r, state_nx;
  logic [DW-1:0] q_r, q_nx;        // dividend shifting out, quotient shifting in
  logic [VW:0]   pr_r, pr_nx;      // partial remainder, one guard bit wide
  logic [VW-1:0] dvs_r, dvs_nx;    // latched divisor
  logic [CW-1:0] cnt_r, cnt_nx;    // quotient bits still to produce
  logic [DW-1:0] quo_nx;
  logic [VW-1:0] rem_nx;
  logic          busy_nx, done_nx, dz_nx;
  logic [VW:0]   pr_shift;
  logic [VW:0]   pr_sub;
  logic          ge;

  // State register and all datapath/output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      q_r       <= {DW{1'b0}};
      pr_r      <= {(VW+1){1'b0}};
      dvs_r     <= {VW{1'b0}};
      cnt_r     <= {CW{1'b0}};
      quotient  <= {DW{1'b0}};
      remainder <= {VW{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      dz        <= 1'b0;
    end else begin
      state_r   <= state_nx;
      q_r       <= q_nx;
      pr_r      <= pr_nx;
      dvs_r     <= dvs_nx;
      cnt_r     <= cnt_nx;
      quotient  <= quo_nx;
      remainder <= rem_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      dz        <= dz_nx;
    end
  end

  // Next-state and next-value logic: accept in IDLE, one restoring step per RUN edge.
  always_comb begin
    state_nx = state_r;
    q_nx     = q_r;
    pr_nx    = pr_r;
    dvs_nx   = dvs_r;
    cnt_nx   = cnt_r;
    quo_nx   = quotient;
    rem_nx   = remainder;
    busy_nx  = busy;
    done_nx  = 1'b0;
    dz_nx    = dz;
    // The guard bit keeps the shifted remainder from wrapping before the compare.
    pr_shift = {pr_r[VW-1:0], q_r[DW-1]};
    pr_sub   = pr_shift - {1'b0, dvs_r};
    ge       = (pr_shift >= {1'b0, dvs_r});

    case (state_r)
      IDLE: begin
        busy_nx = 1'b0;
        if (st) begin
          q_nx   = dividend;
          dvs_nx = divisor;
          pr_nx  = {(VW+1){1'b0}};
          cnt_nx = CW'(DW);
          if (divisor != {VW{1'b0}}) begin
            state_nx = RUN;
            busy_nx  = 1'b1;
          end else begin
            // Divide by zero finishes on the accepting edge itself.
            quo_nx  = {DW{1'b1}};
            rem_nx  = dividend[VW-1:0];
            dz_nx   = 1'b1;
            done_nx = 1'b1;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        q_nx   = {q_r[DW-2:0], ge};
        pr_nx  = ge ? pr_sub : pr_shift;
        cnt_nx = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          dz_nx    = 1'b0;
          quo_nx   = q_nx;
          rem_nx   = pr_nx[VW-1:0];
        end else begin
          busy_nx = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_div16x8.sv
// Scoreboard bench for seq_div16x8: stimulus pushes expected results computed
// with plain integer division; a negedge monitor pops them when done pulses
// and also tracks busy and the held result registers every cycle.
module tb_seq_div16x8;

  logic        clk;
  logic        rst;
  logic        st;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        dz;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          bs = 0;      // first cycle busy is expected high
  int          be = 0;      // first cycle busy is expected low again
  logic [15:0] held_q = 16'h0000;
  logic [7:0]  held_r = 8'h00;
  logic        held_dz = 1'b0;

  seq_div16x8 dut (
    .clk(clk), .rst(rst), .st(st), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done), .dz(dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] dd, input logic [7:0] dv, input int k);
    exp_t e;
    int unsigned a, b;
    a = dd;
    b = dv;
    if (b == 0) begin
      e.q = 16'hFFFF;
      e.r = dd[7:0];
      e.dz = 1'b1;
      e.cyc = k;
    end else begin
      e.q = 16'(a / b);
      e.r = 8'(a % b);
      e.dz = 1'b0;
      e.cyc = k + 16;
    end
    return e;
  endfunction

  // Monitor: pop on done, then compare held outputs and busy every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: done=1, expected 0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc, e.cyc);
          held_q = e.q;
          held_r = e.r;
          held_dz = e.dz;
        end
      end
      chk("quotient", {16'h0, quotient}, {16'h0, held_q});
      chk("remainder", {24'h0, remainder}, {24'h0, held_r});
      chk("dz", {31'h0, dz}, {31'h0, held_dz});
      chk("busy", {31'h0, busy}, {31'h0, (cyc >= bs && cyc < be)});
    end
  end

  // Issue one accepted operation (called at a negedge with the DUT idle).
  task automatic start_op(input logic [15:0] dd, input logic [7:0] dv);
    int k;
    st = 1'b1;
    dividend = dd;
    divisor = dv;
    @(posedge clk);
    #1;
    k = cyc;
    sb.push_back(model(dd, dv, k));
    if (dv != 8'h00) begin
      bs = k;
      be = k + 16;
    end
    @(negedge clk);
    st = 1'b0;
    dividend = 16'($urandom);
    divisor = 8'($urandom);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: %0d results pending, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int k;
    logic [15:0] rdd;
    logic [7:0]  rdv;
    rst = 1'b0;
    st = 1'b0;
    dividend = 16'h0000;
    divisor = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_quotient", {16'h0, quotient}, 32'h0);
    chk("reset_busy_done_dz", {29'h0, busy, done, dz}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases from the plan, including boundaries and divide by zero.
    start_op(16'h0156, 8'h13); wait_idle();
    start_op(16'h0277, 8'h12); wait_idle();
    start_op(16'h00FE, 8'hFF); wait_idle();
    start_op(16'hFFFF, 8'h01); wait_idle();
    start_op(16'hFFFF, 8'hFF); wait_idle();
    start_op(16'h0000, 8'h07); wait_idle();
    start_op(16'h1234, 8'h00); wait_idle();
    chk("dz_result_q", {16'h0, held_q}, 32'h0000FFFF);
    chk("dz_result_r", {24'h0, held_r}, 32'h00000034);

    // A second start while running is ignored.
    start_op(16'h0156, 8'h13);
    repeat (4) @(negedge clk);
    st = 1'b1; dividend = 16'h0277; divisor = 8'h12;
    @(negedge clk);
    st = 1'b0;
    wait_idle();

    // Hold st high across done: restart on the first IDLE edge.
    st = 1'b1; dividend = 16'h0277; divisor = 8'h12;
    @(posedge clk);
    #1;
    k = cyc;
    sb.push_back(model(16'h0277, 8'h12, k));
    bs = k; be = k + 16;
    dividend = 16'h00FE; divisor = 8'hFF;
    repeat (17) @(posedge clk);
    #1;
    sb.push_back(model(16'h00FE, 8'hFF, cyc));
    bs = cyc; be = cyc + 16;
    @(negedge clk);
    st = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of a run.
    start_op(16'h1234, 8'h56);
    repeat (7) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_q", {16'h0, quotient}, 32'h0);
    chk("async_reset_r", {24'h0, remainder}, 32'h0);
    chk("async_reset_flags", {29'h0, busy, done, dz}, 32'h0);
    sb.delete();
    held_q = 16'h0000; held_r = 8'h00; held_dz = 1'b0;
    be = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_op(16'h0276, 8'h12); wait_idle();
    chk("after_reset_q", {16'h0, held_q}, 32'h00000023);

    // Randomized operations, roughly one in ten with a zero divisor.
    for (int i = 0; i < 40; i++) begin
      rdd = 16'($urandom);
      rdv = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      start_op(rdd, rdv);
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_div16x8.md
Name: seq_div16x8

Overview:
- Sequential restoring divider: 16-bit dividend by 8-bit divisor, producing a 16-bit quotient and an 8-bit remainder.
- It is the inverse companion of the 8x8 shift-add multiplier `top`. It uses the same start-pulse handshake, so a multiplier product can be fed back to recover the operand.
- It produces one quotient bit per clock and sits beside the multiplier in the arithmetic datapath.

Parameters:
- DW, 16, dividend and quotient width.
- VW, 8, divisor and remainder width. VW must be less than or equal to DW.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- st  input  1  start request, sampled only in IDLE.
- dividend  input  DW  dividend, captured on the accepting edge.
- divisor  input  VW  divisor, captured on the accepting edge.
- quotient  output  DW  registered quotient, held until the next completion.
- remainder  output  VW  registered remainder, held until the next completion.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle completion pulse.
- dz  output  1  divide-by-zero flag for the last completed operation.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; quotient=0, remainder=0, busy=0, done=0, dz=0, internal counter=0. Reset mid-operation aborts immediately. After rst rises, the next st starts a fresh operation.
- States: IDLE, RUN.
- IDLE:
  - If st=1 at rising edge k, latch dividend into the shift register, latch divisor, clear the (VW+1)-bit partial remainder, and set cnt=DW.
  - If the latched divisor is nonzero, go to RUN with busy=1 after edge k.
  - If the divisor is 0, stay in IDLE. At edge k: quotient={DW{1'b1}}, remainder=dividend[VW-1:0], dz=1, done=1 for one cycle, busy stays 0.
- RUN, each edge:
  - pr_next = {pr[VW-1:0], q[DW-1]}.
  - q shifts left by 1.
  - If pr_next >= {1'b0, divisor}: pr = pr_next - divisor and q[0]=1. Otherwise pr = pr_next and q[0]=0.
  - cnt decrements.
  - The partial remainder is VW+1 bits wide, so the compare never overflows.
- Completion:
  - On the edge where cnt goes 1->0 (edge k+DW), load the final q into quotient and pr[VW-1:0] into remainder.
  - Same edge: dz=0, done=1, busy=0, state returns to IDLE.
  - Latency: done is high during the cycle after edge k+DW, i.e. DW+1 clocks from the st sample.
- done is a single-cycle pulse. It deasserts at the next edge unless a divide-by-zero completion occurs on that edge.
- st while busy=1 is ignored. No queuing.
- st is level-sampled. Holding st high in IDLE restarts an operation on every IDLE edge, including the edge immediately after done.
- Operand inputs may change freely after the accepting edge.
- quotient, remainder and dz change only at a completion edge or on reset.
- All results are unsigned.

Test Plan:
- Reset released, st pulsed with dividend=0x0156, divisor=0x13 -> done exactly 17 clocks after the st sample edge; quotient=0x0012, remainder=0x00, dz=0; busy high for 16 cycles.
- dividend=0x0277, divisor=0x12 -> quotient=0x0023, remainder=0x01. Then dividend=0x00FE, divisor=0xFF -> quotient=0x0000, remainder=0xFE.
- Boundaries: 0xFFFF/0x01 -> quotient=0xFFFF, remainder=0x00. 0xFFFF/0xFF -> quotient=0x0101, remainder=0x00. 0x0000/0x07 -> quotient=0, remainder=0.
- 0x1234/0x00 -> done one edge after st, dz=1, quotient=0xFFFF, remainder=0x34, busy never asserted.
- Protocol: re-pulse st mid-RUN with new operands -> ignored, result matches the first operands. Then hold st high across done -> new operation starts on the first IDLE edge, and quotient holds the previous value until the next completion.
- Drop rst to 0 at cycle 8 of a RUN -> all outputs 0 asynchronously. Release rst, start 0x0276/0x12 -> quotient=0x0023, remainder=0x00 with normal 17-clock latency.
